i2c_bit_engine: RTL
===================

Name: i2c_bit_engine

Overview:
- Bit-level I2C physical stage directly downstream of the I2C transaction FSM.
- Generates the quarter-bit timing strobes STEP1..STEP4 that the FSM consumes (it advances on STEP3, and on STEP4 out of restart).
- Turns the FSM's one-hot command levels (START/RESTART/STOP/SH*/ACK) into open-drain SCL/SDA drive, shifts transmit bytes out MSB-first and assembles received bytes.

Parameters:
- CLK_DIV, 25, CLK cycles per quarter-bit; minimum 2. Bit period = 4*CLK_DIV.
- DIV_W, 8, width of the quarter divider counter; must satisfy 2^DIV_W >= CLK_DIV.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- START, RESTART, STOP  in  1 each  FSM condition-phase levels.
- SHDEVWRT, SHDEVRD, SHADR, SHDATA  in  1 each  FSM shift-phase levels.
- S_ACK, M_ACK, M_NACK  in  1 each  FSM acknowledge-phase levels.
- LOAD_ADDR, LOAD_BYTE, PUSH  in  1 each  FSM load/push levels.
- READ  in  1  transaction direction; 1 = read data bytes.
- DEV_ADDR  in  7  7-bit slave address.
- REG_ADDR  in  8  register address byte.
- WR_BYTE  in  8  current write-data byte.
- SDA_IN  in  1  synchronised SDA pin level.
- SCL_OE  out  1  1 = pull SCL low.
- SDA_OE  out  1  1 = pull SDA low.
- STEP1, STEP2, STEP3, STEP4  out  1 each  one-CLK strobes marking the end of quarters 1..4.
- RD_BYTE  out  8  last received byte.
- RD_VALID  out  1  one-CLK pulse; RD_BYTE updated.
- ACK_ERR  out  1  sticky; a slave NACK was seen.
- BUSY  out  1  any command input high.

Behaviour:
- Reset (RST_N=0, asynchronous): SCL_OE=0, SDA_OE=0, STEP1..4=0, RD_BYTE=0, RD_VALID=0, ACK_ERR=0. Tx and rx shift registers cleared; divider=0; quarter index=Q4.
- RUN = OR of all command inputs; BUSY = RUN (combinational).
- RUN=0: divider held at 0, quarter index held at Q4, no strobes, SCL_OE=0, SDA_OE=0.
- RUN=1: divider counts 0..CLK_DIV-1. On wrap, STEPk (k = current quarter) pulses for one cycle and the quarter advances in the order Q4 -> Q1 -> Q2 -> Q3 -> Q4.
- The first strobe after RUN rises is therefore STEP4, CLK_DIV cycles later.
- Quarter-to-pin mapping (registered; both OE outputs change on the cycle after a strobe):
  - Data/ack bit: Q4 SCL low, SDA set up; Q1 SCL high; Q2 SCL high; Q3 SCL low.
  - START: SDA released in Q4/Q1, driven low from Q2; SCL high Q1-Q2, low from Q3.
  - RESTART: same as START; SCL stays low through the trailing Q4. The FSM leaves on STEP4.
  - STOP: SDA low in Q4/Q1, released from Q2; SCL low in Q4, released from Q1 onward.
- Tx shift register (8 bits):
  - Loaded while START is high with {DEV_ADDR,0}.
  - Loaded while RESTART is high with {DEV_ADDR,1}.
  - Loaded on the rising edge of LOAD_ADDR with REG_ADDR.
  - Loaded on the rising edge of LOAD_BYTE with WR_BYTE.
  - Shifts left, filling 1, on STEP3 while SHDEVWRT, SHDEVRD, SHADR, or (SHDATA and not READ) is high.
  - SDA_OE = ~tx[7] during a shift-write phase.
- Read data (SHDATA and READ): SDA_OE=0. SDA_IN is shifted into the rx LSB on STEP1.
- Rising edge of PUSH: RD_BYTE <= rx and RD_VALID pulses for 1 cycle.
- S_ACK: SDA_OE=0. SDA_IN sampled on STEP1; a 1 sets ACK_ERR.
- M_ACK: SDA_OE=1. M_NACK: SDA_OE=0.
- ACK_ERR clears only on a rising edge of START or on reset.
- Simultaneous events:
  - A load edge coinciding with STEP3 takes the load and drops the shift.
  - A command-input change is sampled on the same edge as the strobe that caused it. The divider does not restart, because RUN stays high between phases.
- Reset mid-transfer: both lines released immediately (asynchronous). No STOP is generated.

Decomposition:
- Shared package i2c_pkg:
  - Quarter encoding Q1..Q4.
  - Constants RW_WRITE=0 and RW_READ=1.
  - Byte width 8.
- One sub-module, i2c_step_gen: divider, quarter index and STEP1..4 generation, with inputs RUN and reset.
- Pin mapping and shift/receive logic stay in the top.

Test Plan (CLK_DIV=4):
- Idle, then START high: first STEP4 at cycle 4, then STEP1/2/3 at 8/12/16. SDA_OE rises after STEP1 while SCL_OE=0; SCL_OE rises after STEP2.
- Write sequence START, SHDEVWRT with DEV_ADDR=0x50 for 8 STEP3s: SDA_OE pattern per bit = inverse of 0xA0 (bits 1,0,1,0,0,0,0,0 MSB-first); 16 CLK per bit.
- S_ACK with SDA_IN=1 at STEP1 -> ACK_ERR=1 and held. Next START rising -> ACK_ERR=0.
- Read byte: SHDATA with READ=1 and SDA_IN supplying 0x3C over 8 bits, then PUSH -> RD_BYTE=0x3C with a 1-cycle RD_VALID.
- STOP: SCL_OE=0 from Q1; SDA_OE falls after STEP1; no strobes once all command inputs are low.
- RST_N pulled low mid-SHADR -> SCL_OE=SDA_OE=0 in the same cycle. After release, the quarter index is Q4 and the divider is 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bit engine: quarter-bit encoding, R/W bit values
// and the byte width used by the shift registers.
package i2c_pkg;

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } quarter_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;
  localparam int   BYTE_W   = 8;

  // A bit cell runs Q4 (setup) -> Q1 -> Q2 -> Q3, then wraps back to Q4.
  function automatic quarter_t next_quarter(input quarter_t q);
    quarter_t n;
    case (q)
      Q4:      n = Q1;
      Q1:      n = Q2;
      Q2:      n = Q3;
      default: n = Q4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/i2c_step_gen.sv
// Quarter-bit timebase: divides the clock by CLK_DIV and emits one-cycle STEP
// strobes marking the end of each quarter while the bus engine is running.
module i2c_step_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter int DIV_W   = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_run,
  output quarter_t   o_quarter,
  output logic [3:0] o_step
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  quarter_t         r_quarter;
  logic [3:0]       r_step;

  // Idle parks the timebase at the start of Q4 so the first strobe after RUN
  // rises is always STEP4, one full quarter later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div     <= '0;
      r_quarter <= Q4;
      r_step    <= '0;
    end else if (!i_run) begin
      r_div     <= '0;
      r_quarter <= Q4;
      r_step    <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div     <= '0;
      r_step    <= 4'b0001 << r_quarter;
      r_quarter <= next_quarter(r_quarter);
    end else begin
      r_div     <= r_div + 1'b1;
      r_step    <= '0;
    end
  end

  assign o_quarter = r_quarter;
  assign o_step    = r_step;

endmodule

// File: rtl/i2c_bit_engine.sv
// Bit-level I2C stage: maps the transaction FSM's phase levels onto open-drain
// SCL/SDA drive, shifts bytes out MSB-first and assembles received bytes.
module i2c_bit_engine
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter int DIV_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_restart,
  input  logic              i_stop,
  input  logic              i_shdevwrt,
  input  logic              i_shdevrd,
  input  logic              i_shadr,
  input  logic              i_shdata,
  input  logic              i_s_ack,
  input  logic              i_m_ack,
  input  logic              i_m_nack,
  input  logic              i_load_addr,
  input  logic              i_load_byte,
  input  logic              i_push,
  input  logic              i_read,
  input  logic [6:0]        i_dev_addr,
  input  logic [BYTE_W-1:0] i_reg_addr,
  input  logic [BYTE_W-1:0] i_wr_byte,
  input  logic              i_sda_in,
  output logic              o_scl_oe,
  output logic              o_sda_oe,
  output logic              o_step1,
  output logic              o_step2,
  output logic              o_step3,
  output logic              o_step4,
  output logic [BYTE_W-1:0] o_rd_byte,
  output logic              o_rd_valid,
  output logic              o_ack_err,
  output logic              o_busy
);

  logic              w_run;
  quarter_t          w_quarter;
  logic [3:0]        w_step;
  logic              w_rd_phase;
  logic              w_tx_phase;
  logic              w_bit_phase;
  logic              w_bit_sda;
  logic              w_scl_nxt;
  logic              w_sda_nxt;
  logic              w_start_rise;
  logic              w_load_addr_rise;
  logic              w_load_byte_rise;
  logic              w_push_rise;

  logic              r_scl_oe;
  logic              r_sda_oe;
  logic [BYTE_W-1:0] r_tx;
  logic [BYTE_W-1:0] r_rx;
  logic [BYTE_W-1:0] r_rd_byte;
  logic              r_rd_valid;
  logic              r_ack_err;
  logic              r_start_d;
  logic              r_load_addr_d;
  logic              r_load_byte_d;
  logic              r_push_d;

  assign w_run = i_start | i_restart | i_stop | i_shdevwrt | i_shdevrd | i_shadr |
                 i_shdata | i_s_ack | i_m_ack | i_m_nack | i_load_addr |
                 i_load_byte | i_push;

  i2c_step_gen #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_step_gen (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_run     (w_run),
    .o_quarter (w_quarter),
    .o_step    (w_step)
  );

  assign w_rd_phase  = i_shdata & (i_read == RW_READ);
  assign w_tx_phase  = i_shdevwrt | i_shdevrd | i_shadr | (i_shdata & (i_read == RW_WRITE));
  assign w_bit_phase = w_tx_phase | w_rd_phase | i_s_ack | i_m_ack | i_m_nack;
  assign w_bit_sda   = w_tx_phase ? ~r_tx[BYTE_W-1] : i_m_ack;

  assign w_start_rise     = i_start & ~r_start_d;
  assign w_load_addr_rise = i_load_addr & ~r_load_addr_d;
  assign w_load_byte_rise = i_load_byte & ~r_load_byte_d;
  assign w_push_rise      = i_push & ~r_push_d;

  // START holds the lines in Q4 so the one cycle where the following phase's
  // Q4 is seen under START does not release SCL between Q3 and the next bit.
  always_comb begin
    w_scl_nxt = r_scl_oe;
    w_sda_nxt = r_sda_oe;
    if (!w_run) begin
      w_scl_nxt = 1'b0;
      w_sda_nxt = 1'b0;
    end else if (i_start | i_restart) begin
      case (w_quarter)
        Q4: begin
          if (i_restart) begin
            w_scl_nxt = 1'b1;
            w_sda_nxt = 1'b0;
          end
        end
        Q1: begin
          w_scl_nxt = 1'b0;
          w_sda_nxt = 1'b0;
        end
        Q2: begin
          w_scl_nxt = 1'b0;
          w_sda_nxt = 1'b1;
        end
        default: begin
          w_scl_nxt = 1'b1;
          w_sda_nxt = 1'b1;
        end
      endcase
    end else if (i_stop) begin
      w_scl_nxt = (w_quarter == Q4);
      w_sda_nxt = (w_quarter == Q4) | (w_quarter == Q1);
    end else if (w_bit_phase) begin
      w_scl_nxt = (w_quarter == Q3) | (w_quarter == Q4);
      w_sda_nxt = w_bit_sda;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_oe      <= 1'b0;
      r_sda_oe      <= 1'b0;
      r_start_d     <= 1'b0;
      r_load_addr_d <= 1'b0;
      r_load_byte_d <= 1'b0;
      r_push_d      <= 1'b0;
    end else begin
      r_scl_oe      <= w_scl_nxt;
      r_sda_oe      <= w_sda_nxt;
      r_start_d     <= i_start;
      r_load_addr_d <= i_load_addr;
      r_load_byte_d <= i_load_byte;
      r_push_d      <= i_push;
    end
  end

  // A load landing on the same edge as STEP3 wins; the shift of the old byte
  // is dropped because that byte has already been fully sent.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx <= '0;
    end else if (i_start) begin
      r_tx <= {i_dev_addr, RW_WRITE};
    end else if (i_restart) begin
      r_tx <= {i_dev_addr, RW_READ};
    end else if (w_load_addr_rise) begin
      r_tx <= i_reg_addr;
    end else if (w_load_byte_rise) begin
      r_tx <= i_wr_byte;
    end else if (w_step[2] && w_tx_phase) begin
      r_tx <= {r_tx[BYTE_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx       <= '0;
      r_rd_byte  <= '0;
      r_rd_valid <= 1'b0;
      r_ack_err  <= 1'b0;
    end else begin
      if (w_step[0] && w_rd_phase) begin
        r_rx <= {r_rx[BYTE_W-2:0], i_sda_in};
      end
      r_rd_valid <= w_push_rise;
      if (w_push_rise) begin
        r_rd_byte <= r_rx;
      end
      if (w_start_rise) begin
        r_ack_err <= 1'b0;
      end else if (w_step[0] && i_s_ack && i_sda_in) begin
        r_ack_err <= 1'b1;
      end
    end
  end

  assign o_scl_oe   = r_scl_oe;
  assign o_sda_oe   = r_sda_oe;
  assign o_step1    = w_step[0];
  assign o_step2    = w_step[1];
  assign o_step3    = w_step[2];
  assign o_step4    = w_step[3];
  assign o_rd_byte  = r_rd_byte;
  assign o_rd_valid = r_rd_valid;
  assign o_ack_err  = r_ack_err;
  assign o_busy     = w_run;

endmodule
